mantissa_aligner: RTL and testbench

MANTISSA_ALIGNER -- requirements
Module: mantissa_aligner

---
 rtl/mantissa_aligner.sv | 215 +++++++++++++++++++++
 tb/tb_mantissa_aligner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_aligner.sv
// Aligns the mantissas of two IEEE-754 singles: picks the larger magnitude and right-shifts
// the smaller through a 5-layer barrel shifter, one layer per cycle. Define MANTISSA_ALIGNER_STICKY_EN for sticky.
module mantissa_aligner (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] m_big,
    output logic [24:0] m_small,
    output logic [7:0]  e_out,
    output logic        sign_big,
    output logic        sign_small,
    output logic        swapped,
    output logic        sticky
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Denormals (exponent field 0) behave as exponent 1 with no hidden bit.
    function automatic logic [7:0] eff_exp(input logic [31:0] f);
        eff_exp = (f[30:23] == 8'd0) ? 8'd1 : f[30:23];
    endfunction

    function automatic logic [24:0] mant(input logic [31:0] f);
        mant = {(f[30:23] != 8'd0), f[22:0], 1'b0};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [24:0] m_big_q, m_big_d, m_small_q, m_small_d;
    logic [7:0]  e_out_q, e_out_d;
    logic        sign_big_q, sign_big_d, sign_small_q, sign_small_d;
    logic        swapped_q, swapped_d;
    logic [4:0]  diff_q, diff_d;
    logic [2:0]  layer_q, layer_d;

    logic [7:0]  ea_s, eb_s, diff_raw_s;
    logic        swap_s;
    logic [4:0]  shamt_s;
    logic        layer_en_s;
    logic [24:0] shifted_s;

`ifdef MANTISSA_ALIGNER_STICKY_EN
    logic        sticky_q, sticky_d;
    logic        lost_s;
`endif

    // Magnitude compare of the captured operands.
    always_comb begin
        ea_s   = eff_exp(a_q);
        eb_s   = eff_exp(b_q);
        swap_s = (eb_s > ea_s) || ((eb_s == ea_s) && (b_q[22:0] > a_q[22:0]));
        if (swap_s) begin
            diff_raw_s = eb_s - ea_s;
        end else begin
            diff_raw_s = ea_s - eb_s;
        end
    end

    // Current shifter layer: weight 16 first, down to weight 1; each gated by its diff bit.
    always_comb begin
        case (layer_q)
            3'd0:    begin shamt_s = 5'd16; layer_en_s = diff_q[4]; end
            3'd1:    begin shamt_s = 5'd8;  layer_en_s = diff_q[3]; end
            3'd2:    begin shamt_s = 5'd4;  layer_en_s = diff_q[2]; end
            3'd3:    begin shamt_s = 5'd2;  layer_en_s = diff_q[1]; end
            3'd4:    begin shamt_s = 5'd1;  layer_en_s = diff_q[0]; end
            default: begin shamt_s = 5'd0;  layer_en_s = 1'b0;      end
        endcase
        shifted_s = m_small_q >> shamt_s;
`ifdef MANTISSA_ALIGNER_STICKY_EN
        lost_s = |(m_small_q & ((25'd1 << shamt_s) - 25'd1));
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        m_big_d      = m_big_q;
        m_small_d    = m_small_q;
        e_out_d      = e_out_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        swapped_d    = swapped_q;
        diff_d       = diff_q;
        layer_d      = layer_q;
`ifdef MANTISSA_ALIGNER_STICKY_EN
        sticky_d     = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = CMP;
                end else begin
                    state_d = IDLE;
                end
            end
            CMP: begin
                if (swap_s) begin
                    m_big_d      = mant(b_q);
                    m_small_d    = mant(a_q);
                    e_out_d      = eb_s;
                    sign_big_d   = b_q[31];
                    sign_small_d = a_q[31];
                end else begin
                    m_big_d      = mant(a_q);
                    m_small_d    = mant(b_q);
                    e_out_d      = ea_s;
                    sign_big_d   = a_q[31];
                    sign_small_d = b_q[31];
                end
                swapped_d = swap_s;
                diff_d    = (diff_raw_s > 8'd31) ? 5'd31 : diff_raw_s[4:0];
                layer_d   = 3'd0;
`ifdef MANTISSA_ALIGNER_STICKY_EN
                sticky_d  = 1'b0;
`endif
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (layer_en_s) begin
                    m_small_d = shifted_s;
`ifdef MANTISSA_ALIGNER_STICKY_EN
                    sticky_d  = sticky_q | lost_s;
`endif
                end else begin
                    m_small_d = m_small_q;
                end
                if (layer_q == 3'd4) begin
                    layer_d = 3'd0;
                    state_d = DONE;
                end else begin
                    layer_d = layer_q + 3'd1;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            m_big_q      <= 25'd0;
            m_small_q    <= 25'd0;
            e_out_q      <= 8'd0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swapped_q    <= 1'b0;
            diff_q       <= 5'd0;
            layer_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            m_big_q      <= m_big_d;
            m_small_q    <= m_small_d;
            e_out_q      <= e_out_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            swapped_q    <= swapped_d;
            diff_q       <= diff_d;
            layer_q      <= layer_d;
        end
    end

`ifdef MANTISSA_ALIGNER_STICKY_EN
    // Sticky accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end
    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign m_big      = m_big_q;
    assign m_small    = m_small_q;
    assign e_out      = e_out_q;
    assign sign_big   = sign_big_q;
    assign sign_small = sign_small_q;
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_mantissa_aligner.sv
// Randomized bench for mantissa_aligner: an arithmetic reference model feeds an expected-result
// queue that a per-cycle compare process checks; directed vectors pin literal results.
module tb_mantissa_aligner;

    typedef struct packed {
        logic [24:0] mb;
        logic [24:0] ms;
        logic [7:0]  e;
        logic        sb;
        logic        ss;
        logic        sw;
        logic        st;
    } res_t;

`ifdef MANTISSA_ALIGNER_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] m_big, m_small;
    logic [7:0]  e_out;
    logic        sign_big, sign_small, swapped, sticky;

    int checks = 0;
    int errors = 0;
    res_t exp_q[$];
    logic [61:0] dut_res;

    mantissa_aligner dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .m_big(m_big), .m_small(m_small), .e_out(e_out),
        .sign_big(sign_big), .sign_small(sign_small), .swapped(swapped), .sticky(sticky)
    );

    always #5 clk = ~clk;

    assign dut_res = {m_big, m_small, e_out, sign_big, sign_small, swapped, sticky};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: whole-magnitude comparison and an exact arithmetic shift by the true difference.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        int unsigned ex, ey, mx, my, mbig, msmall, d, lost;
        bit bsw;
        res_t r;
        ex  = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        ey  = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
        mx  = ((x[30:23] != 8'd0) ? 32'h0100_0000 : 0) + int'(x[22:0]) * 2;
        my  = ((y[30:23] != 8'd0) ? 32'h0100_0000 : 0) + int'(y[22:0]) * 2;
        bsw = (ey > ex) || ((ey == ex) && (y[22:0] > x[22:0]));
        mbig   = bsw ? my : mx;
        msmall = bsw ? mx : my;
        d      = bsw ? ey - ex : ex - ey;
        if (d >= 25) begin
            r.ms = 25'd0;
            lost = msmall;
        end else begin
            r.ms = 25'(msmall >> d);
            lost = msmall % (32'd1 << d);
        end
        r.mb = 25'(mbig);
        r.e  = 8'(bsw ? ey : ex);
        r.sb = bsw ? y[31] : x[31];
        r.ss = bsw ? x[31] : y[31];
        r.sw = bsw;
        r.st = STK && (lost != 0);
        return r;
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid actual=1 expected=0 at %0t", $time);
            end else begin
                chk("result", {2'b00, dut_res}, {2'b00, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input int hold,
                        input bit lit_en, input res_t lit);
        int n;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_send", {63'd0, in_ready}, 64'd1);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(xa, xb));
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 20);
        chk("latency", 64'(n), 64'd6);
        if (lit_en) chk("literal", {2'b00, dut_res}, {2'b00, lit});
        for (int h = 0; h < hold; h++) begin
            chk("busy_in_done", {63'd0, in_ready}, 64'd0);
            if (h == 1) in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_to_idle", {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        res_t lit;
        logic [31:0] ra, rb;
        int mode;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {2'b00, dut_res}, 64'd0);
        chk("reset_handshake", {62'd0, in_ready, out_valid}, 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        lit = '{mb: 25'h1000000, ms: 25'h0800000, e: 8'h7F, sb: 1'b0, ss: 1'b0, sw: 1'b0, st: 1'b0};
        send(32'h3F800000, 32'h3F000000, 0, 1'b1, lit);
        lit = '{mb: 25'h1000000, ms: 25'h0400000, e: 8'h80, sb: 1'b0, ss: 1'b0, sw: 1'b1, st: 1'b0};
        send(32'h3F000000, 32'h40000000, 1, 1'b1, lit);
        lit = '{mb: 25'h1000000, ms: 25'h0000001, e: 8'h97, sb: 1'b0, ss: 1'b0, sw: 1'b0, st: STK};
        send(32'h4B800000, 32'h3F800001, 0, 1'b1, lit);
        lit = '{mb: 25'h1000000, ms: 25'h0000000, e: 8'hFE, sb: 1'b0, ss: 1'b0, sw: 1'b0, st: STK};
        send(32'h7F000000, 32'h3F800000, 2, 1'b1, lit);
        lit = '{mb: 25'h1921FB6, ms: 25'h1921FB6, e: 8'h80, sb: 1'b1, ss: 1'b1, sw: 1'b0, st: 1'b0};
        send(32'hC0490FDB, 32'hC0490FDB, 0, 1'b1, lit);
        // Long back-pressure with an ignored in_valid pulse.
        lit = '{mb: 25'h1000000, ms: 25'h0800000, e: 8'h7F, sb: 1'b0, ss: 1'b1, sw: 1'b1, st: 1'b0};
        send(32'hBF000000, 32'h3F800000, 10, 1'b1, lit);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            mode = $urandom_range(0, 3);
            if (mode == 1) rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 31));
            else if (mode == 2) rb = ra;
            else if (mode == 3) rb[30:23] = ra[30:23];
            send(ra, rb, $urandom_range(0, 3), 1'b0, lit);
        end

        // Reset while shifting discards the operation.
        a = 32'h3F800000;
        b = 32'h3F000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", {2'b00, dut_res}, 64'd0);
        chk("reset_mid_handshake", {62'd0, in_ready, out_valid}, 64'd2);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("no_valid_after_reset", {63'd0, out_valid}, 64'd0);
        end

        lit = '{mb: 25'h1000000, ms: 25'h0400000, e: 8'h80, sb: 1'b0, ss: 1'b0, sw: 1'b1, st: 1'b0};
        send(32'h3F000000, 32'h40000000, 0, 1'b1, lit);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
